// File: rtl/video_timing_reader.sv
// Programmable video timing generator that pulls one frame per request from a
// frame-buffer read port and realigns hs/vs/de to the returned pixel data.
module video_timing_reader #(
    parameter int unsigned            DATA_WIDTH = 16,
    parameter int unsigned            H_ACTIVE   = 1280,
    parameter int unsigned            H_FP       = 110,
    parameter int unsigned            H_SYNC     = 40,
    parameter int unsigned            H_BP       = 220,
    parameter int unsigned            V_ACTIVE   = 720,
    parameter int unsigned            V_FP       = 5,
    parameter int unsigned            V_SYNC     = 5,
    parameter int unsigned            V_BP       = 20,
    parameter bit                     HS_POL     = 1'b1,
    parameter bit                     VS_POL     = 1'b1,
    parameter int unsigned            RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0]  FILL_VALUE = '0
) (
    input  logic                  i_video_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    output logic                  o_read_req,
    input  logic                  i_read_req_ack,
    output logic                  o_read_en,
    input  logic [DATA_WIDTH-1:0] i_read_data,
    output logic                  o_hs,
    output logic                  o_vs,
    output logic                  o_de,
    output logic [DATA_WIDTH-1:0] o_vout_data,
    output logic                  o_frame_skip
);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W          = $clog2(H_TOTAL);
    localparam int unsigned V_W          = $clog2(V_TOTAL);
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_GRANTED = 2'd2
    } state_t;

    logic [H_W-1:0] r_h_cnt;
    logic [V_W-1:0] r_v_cnt;
    logic           r_run;
    state_t         r_state;
    state_t         w_state_next;
    logic           r_frame_valid;
    logic           w_frame_valid_next;
    logic           w_read_req_next;
    logic           w_frame_skip_next;
    logic           w_granted;

    logic [RD_LATENCY-1:0] r_de_pipe;
    logic [RD_LATENCY-1:0] r_hs_pipe;
    logic [RD_LATENCY-1:0] r_vs_pipe;
    logic [RD_LATENCY-1:0] r_fv_pipe;

    logic w_h_last;
    logic w_v_last;
    logic w_frame_wrap;
    logic w_vs_start;
    logic w_de_i;
    logic w_hs_i;
    logic w_vs_i;

    // r_run lags enable by one clock so every run starts with a clean h=0, v=0 cycle
    assign w_h_last     = (32'(r_h_cnt) == H_TOTAL - 1);
    assign w_v_last     = (32'(r_v_cnt) == V_TOTAL - 1);
    assign w_frame_wrap = r_run && w_h_last && w_v_last;
    assign w_vs_start   = r_run && (32'(r_v_cnt) == V_SYNC_START) && (r_h_cnt == '0);

    assign w_de_i = r_run && (32'(r_h_cnt) < H_ACTIVE) && (32'(r_v_cnt) < V_ACTIVE);
    assign w_hs_i = r_run && (32'(r_h_cnt) >= H_SYNC_START) && (32'(r_h_cnt) < H_SYNC_END);
    assign w_vs_i = r_run && (32'(r_v_cnt) >= V_SYNC_START) && (32'(r_v_cnt) < V_SYNC_END);

    assign o_read_en = w_de_i && r_frame_valid;

    // Horizontal / vertical counters
    always_ff @(posedge i_video_clk or posedge i_rst) begin
        if (i_rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_run   <= 1'b0;
        end else if (!i_enable) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_run   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                if (w_h_last) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
                end else begin
                    r_h_cnt <= r_h_cnt + 1'b1;
                end
            end
        end
    end

    // Request FSM state and its registered outputs
    always_ff @(posedge i_video_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_frame_valid <= 1'b0;
            o_read_req    <= 1'b0;
            o_frame_skip  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_frame_valid <= w_frame_valid_next;
            o_read_req    <= w_read_req_next;
            o_frame_skip  <= w_frame_skip_next;
        end
    end

    // Request FSM next state; an ack landing in the wrap clock still grants the next frame
    always_comb begin
        w_state_next       = r_state;
        w_frame_valid_next = r_frame_valid;
        w_read_req_next    = o_read_req;
        w_frame_skip_next  = 1'b0;
        w_granted          = (r_state == ST_GRANTED) ||
                             ((r_state == ST_REQ) && i_read_req_ack);

        if (!i_enable) begin
            w_state_next       = ST_IDLE;
            w_frame_valid_next = 1'b0;
            w_read_req_next    = 1'b0;
        end else if (!r_run) begin
            w_state_next       = ST_IDLE;
            w_frame_valid_next = 1'b0;
            w_read_req_next    = 1'b0;
            w_frame_skip_next  = 1'b1;
        end else if (w_frame_wrap) begin
            w_state_next       = ST_IDLE;
            w_frame_valid_next = w_granted;
            w_read_req_next    = 1'b0;
            w_frame_skip_next  = !w_granted;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_vs_start) begin
                        w_state_next    = ST_REQ;
                        w_read_req_next = 1'b1;
                    end
                end
                ST_REQ: begin
                    if (i_read_req_ack) begin
                        w_state_next    = ST_GRANTED;
                        w_read_req_next = 1'b0;
                    end
                end
                ST_GRANTED: begin
                    w_state_next = ST_GRANTED;
                end
                default: begin
                    w_state_next    = ST_IDLE;
                    w_read_req_next = 1'b0;
                end
            endcase
        end
    end

    // Delay line matching timing signals to the read latency
    always_ff @(posedge i_video_clk or posedge i_rst) begin
        if (i_rst) begin
            r_de_pipe <= '0;
            r_hs_pipe <= '0;
            r_vs_pipe <= '0;
            r_fv_pipe <= '0;
        end else if (!i_enable) begin
            r_de_pipe <= '0;
            r_hs_pipe <= '0;
            r_vs_pipe <= '0;
            r_fv_pipe <= '0;
        end else begin
            r_de_pipe[0] <= w_de_i;
            r_hs_pipe[0] <= w_hs_i;
            r_vs_pipe[0] <= w_vs_i;
            r_fv_pipe[0] <= r_frame_valid;
            for (int unsigned k = 1; k < RD_LATENCY; k++) begin
                r_de_pipe[k] <= r_de_pipe[k-1];
                r_hs_pipe[k] <= r_hs_pipe[k-1];
                r_vs_pipe[k] <= r_vs_pipe[k-1];
                r_fv_pipe[k] <= r_fv_pipe[k-1];
            end
        end
    end

    // Output stage: polarity applied here, data muxed on the latency-aligned de/valid
    always_ff @(posedge i_video_clk or posedge i_rst) begin
        if (i_rst) begin
            o_hs        <= ~HS_POL;
            o_vs        <= ~VS_POL;
            o_de        <= 1'b0;
            o_vout_data <= '0;
        end else if (!i_enable) begin
            o_hs        <= ~HS_POL;
            o_vs        <= ~VS_POL;
            o_de        <= 1'b0;
            o_vout_data <= '0;
        end else begin
            o_hs <= r_hs_pipe[RD_LATENCY-1] ^ ~HS_POL;
            o_vs <= r_vs_pipe[RD_LATENCY-1] ^ ~VS_POL;
            o_de <= r_de_pipe[RD_LATENCY-1];
            if (r_de_pipe[RD_LATENCY-1]) begin
                o_vout_data <= r_fv_pipe[RD_LATENCY-1] ? i_read_data : FILL_VALUE;
            end else begin
                o_vout_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_reader.sv
// Scoreboard bench for video_timing_reader on a tiny 8x6 raster with read latency 2;
// a second instance with inverted sync polarity shares all inputs.
module tb_video_timing_reader;

    localparam logic [15:0] FILL = 16'h0F0F;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        ack;
    logic [15:0] rdata;

    logic        req, ren, hs, vs, de, skip;
    logic [15:0] vout;
    logic        req_n, ren_n, hs_n, vs_n, de_n, skip_n;
    logic [15:0] vout_n;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [15:0] mem_cnt, m1, m2;

    always #5 clk = ~clk;

    video_timing_reader #(
        .DATA_WIDTH(16), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .RD_LATENCY(2), .FILL_VALUE(FILL)
    ) dut (
        .i_video_clk(clk), .i_rst(rst), .i_enable(en),
        .o_read_req(req), .i_read_req_ack(ack), .o_read_en(ren),
        .i_read_data(rdata), .o_hs(hs), .o_vs(vs), .o_de(de),
        .o_vout_data(vout), .o_frame_skip(skip)
    );

    video_timing_reader #(
        .DATA_WIDTH(16), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LATENCY(2), .FILL_VALUE(FILL)
    ) dut_n (
        .i_video_clk(clk), .i_rst(rst), .i_enable(en),
        .o_read_req(req_n), .i_read_req_ack(ack), .o_read_en(ren_n),
        .i_read_data(rdata), .o_hs(hs_n), .o_vs(vs_n), .o_de(de_n),
        .o_vout_data(vout_n), .o_frame_skip(skip_n)
    );

    // Frame-buffer model: returns the running pixel index two clocks after each strobe
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cnt <= 16'd0;
            m1      <= 16'hDEAD;
            m2      <= 16'hDEAD;
        end else begin
            m1 <= ren ? mem_cnt : 16'hDEAD;
            m2 <= m1;
            if (!en)
                mem_cnt <= 16'd0;
            else if (ren)
                mem_cnt <= (mem_cnt == 16'd11) ? 16'd0 : mem_cnt + 16'd1;
        end
    end
    assign rdata = m2;

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Run ncyc clocks from a fresh enable; mode 0 never acks, 1 acks one clock after
    // read_req rises, 2 acks in the frame-wrap clock
    task automatic run_cycles(input string name, input int ncyc, input int mode);
        int   pos, f, h, v;
        logic de_i, hs_i, vs_i, valid, exp_req, exp_skip, exp_ren;
        exp_t e, got;
        sb.delete();
        repeat (3) sb.push_back('0);
        en = 1'b1;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clk);
            pos   = n % 48;
            f     = n / 48;
            h     = pos % 8;
            v     = pos / 8;
            valid = (f > 0) && (mode != 0);
            de_i  = (h < 4) && (v < 3);
            hs_i  = (h >= 5) && (h < 7);
            vs_i  = (v == 4);
            exp_ren  = de_i && valid;
            exp_skip = (pos == 0) && !valid;
            exp_req  = (mode == 1) ? (pos == 33 || pos == 34) : (pos >= 33);
            ack = ((mode == 1) && (pos == 34)) || ((mode == 2) && (pos == 47));

            e.de   = de_i;
            e.hs   = hs_i;
            e.vs   = vs_i;
            e.data = !de_i ? 16'h0000 : (valid ? 16'(v * 4 + h) : FILL);
            sb.push_back(e);
            got = sb.pop_front();

            vectors += 6;
            if (ren !== exp_ren) begin
                miscompares++;
                $display("FAIL %s read_en n=%0d got %b exp %b", name, n, ren, exp_ren);
            end
            if (skip !== exp_skip) begin
                miscompares++;
                $display("FAIL %s frame_skip n=%0d got %b exp %b", name, n, skip, exp_skip);
            end
            if (req !== exp_req) begin
                miscompares++;
                $display("FAIL %s read_req n=%0d got %b exp %b", name, n, req, exp_req);
            end
            if (de !== got.de) begin
                miscompares++;
                $display("FAIL %s de n=%0d got %b exp %b", name, n, de, got.de);
            end
            if ({hs, vs, hs_n, vs_n} !== {got.hs, got.vs, ~got.hs, ~got.vs}) begin
                miscompares++;
                $display("FAIL %s hs/vs/hs_n/vs_n n=%0d got %b%b%b%b exp %b%b%b%b", name, n,
                         hs, vs, hs_n, vs_n, got.hs, got.vs, ~got.hs, ~got.vs);
            end
            if (vout !== got.data) begin
                miscompares++;
                $display("FAIL %s vout_data n=%0d got %h exp %h", name, n, vout, got.data);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        ack = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({req, ren, de, skip, hs, vs, hs_n, vs_n, vout} !== {8'b0000_0011, 16'h0000}) begin
            miscompares++;
            $display("FAIL reset_values got %b_%h exp 00000011_0000",
                     {req, ren, de, skip, hs, vs, hs_n, vs_n}, vout);
        end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_no_ack();
        do_reset();
        run_cycles("no_ack", 96, 0);
    endtask

    task automatic test_ack_next();
        do_reset();
        run_cycles("ack_next", 144, 1);
    endtask

    task automatic test_ack_at_wrap();
        do_reset();
        run_cycles("ack_wrap", 96, 2);
    endtask

    task automatic test_enable_drop();
        do_reset();
        run_cycles("pre_drop", 58, 1);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if ({req, ren, de, skip, hs, vs, hs_n, vs_n, vout} !== {8'b0000_0011, 16'h0000}) begin
                miscompares++;
                $display("FAIL enable_low_idle k=%0d got %b_%h exp 00000011_0000", k,
                         {req, ren, de, skip, hs, vs, hs_n, vs_n}, vout);
            end
        end
        run_cycles("restart", 96, 1);
    endtask

    task automatic test_async_reset();
        do_reset();
        run_cycles("pre_rst", 60, 1);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({req, ren, de, skip, hs, vs, hs_n, vs_n, vout} !== {8'b0000_0011, 16'h0000}) begin
            miscompares++;
            $display("FAIL async_reset got %b_%h exp 00000011_0000",
                     {req, ren, de, skip, hs, vs, hs_n, vs_n}, vout);
        end
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_no_ack();
        test_ack_next();
        test_ack_at_wrap();
        test_enable_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
